// File: rtl/gray_stream_decoder.sv
// Gray-code stream receiver: converts each valid gray sample to binary and checks
// that it is the +1 successor of the previously accepted value (wrap allowed).
// Repeats are reported as stalls. Any other step is an error that resyncs to the
// new value and bumps a saturating error counter.
//
// Handshake: gray_valid qualifies gray_in for one cycle. There is no ready; every
// valid sample is accepted. All results appear one cycle later, with bin_valid
// as a one-cycle pulse.
module gray_stream_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             wrap,
  output logic             stall,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);

  // UNLOCKED: no reference sample held yet. LOCKED: the stream is being checked.
  // The state is visible externally through the locked output.
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] bin_q, bin_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             bin_valid_q, bin_valid_n;
  logic             wrap_q, wrap_n;
  logic             stall_q, stall_n;
  logic             err_q, err_n;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] exp_c;

  // Gray to binary conversion: each binary bit is the XOR of all gray bits above and at it.
  always_comb begin
    bin_c = '0;
    bin_c[WIDTH-1] = gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_c[i] = bin_c[i+1] ^ gray_in[i];
    end
  end

  assign exp_c = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state and next-output decision for the accepted sample.
  always_comb begin
    state_n     = state_q;
    bin_n       = bin_q;
    cnt_n       = cnt_q;
    bin_valid_n = 1'b0;
    wrap_n      = 1'b0;
    stall_n     = 1'b0;
    err_n       = 1'b0;
    if (gray_valid) begin
      bin_valid_n = 1'b1;
      unique case (state_q)
        UNLOCKED: begin
          bin_n   = bin_c;
          state_n = LOCKED;
        end
        LOCKED: begin
          if (bin_c == exp_c) begin
            bin_n  = bin_c;
            // A +1 step that lands on zero can only come from all-ones.
            wrap_n = (bin_c == '0);
          end else if (bin_c == bin_q) begin
            stall_n = 1'b1;
          end else begin
            err_n = 1'b1;
            bin_n = bin_c;
            if (cnt_q != '1) cnt_n = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  // State and output registers; synchronous reset has priority over gray_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      bin_q       <= '0;
      cnt_q       <= '0;
      bin_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      bin_q       <= bin_n;
      cnt_q       <= cnt_n;
      bin_valid_q <= bin_valid_n;
      wrap_q      <= wrap_n;
      stall_q     <= stall_n;
      err_q       <= err_n;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign locked    = (state_q == LOCKED);
  assign wrap      = wrap_q;
  assign stall     = stall_q;
  assign step_err  = err_q;
  assign err_count = cnt_q;

endmodule
